// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: registered sync/blank/colour/coordinates,
// a lead-time pixel request to the host and frame-aligned test patterns.
module vga_timing_gen_param #(
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 12,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int REQ_LEAD = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic [1:0]         iMODE,
  input  logic [COLOR_W-1:0] inRed,
  input  logic [COLOR_W-1:0] inGreen,
  input  logic [COLOR_W-1:0] inBlue,
  output logic               outRequest,
  output logic [CNT_W-1:0]   outX,
  output logic [CNT_W-1:0]   outY,
  output logic               outFrameStart,
  output logic [COLOR_W-1:0] outVGA_R,
  output logic [COLOR_W-1:0] outVGA_G,
  output logic [COLOR_W-1:0] outVGA_B,
  output logic               outVGA_H_SYNC,
  output logic               outVGA_V_SYNC,
  output logic               outVGA_SYNC,
  output logic               outVGA_BLANK
);

  localparam int X_START_I = H_SYNC + H_BP;
  localparam int Y_START_I = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(X_START_I + H_ACT + H_FP - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(Y_START_I + V_ACT + V_FP - 1);
  localparam logic [CNT_W-1:0] X_START   = CNT_W'(X_START_I);
  localparam logic [CNT_W-1:0] X_END     = CNT_W'(X_START_I + H_ACT);
  localparam logic [CNT_W-1:0] Y_START   = CNT_W'(Y_START_I);
  localparam logic [CNT_W-1:0] Y_END     = CNT_W'(Y_START_I + V_ACT);
  localparam logic [CNT_W-1:0] REQ_START = CNT_W'(X_START_I - REQ_LEAD - 1);
  localparam logic [CNT_W-1:0] REQ_END   = CNT_W'(X_START_I + H_ACT - REQ_LEAD - 1);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] BAR_W     = CNT_W'(H_ACT / 8);
  localparam logic             H_ACTV    = 1'(H_POL);
  localparam logic             V_ACTV    = 1'(V_POL);

  logic [CNT_W-1:0]   hQ, hD, vQ, vD, xQ, xD, yQ, yD, xPos, yPos;
  logic [1:0]         modeQ, modeD;
  logic [2:0]         barIdx;
  logic               hAct, vAct, act;
  logic               hsQ, hsD, vsQ, vsD, blankQ, blankD, reqQ, reqD, fsQ, fsD;
  logic [COLOR_W-1:0] rQ, rD, gQ, gD, bQ, bD;

  // Next-state counters and the output values for the current counter position;
  // the request window is offset so host data arrives exactly REQ_LEAD cycles later.
  always_comb begin
    hD    = hQ;
    vD    = vQ;
    modeD = modeQ;
    if (!iEN) begin
      hD = '0;
      vD = '0;
    end else begin
      if (hQ == H_LAST) begin
        hD = '0;
        vD = (vQ == V_LAST) ? '0 : vQ + CNT_W'(1);
      end else begin
        hD = hQ + CNT_W'(1);
      end
      if (hQ == '0 && vQ == '0) modeD = iMODE;
    end

    hAct   = (hQ >= X_START) && (hQ < X_END);
    vAct   = (vQ >= Y_START) && (vQ < Y_END);
    act    = iEN && hAct && vAct;
    xPos   = hQ - X_START;
    yPos   = vQ - Y_START;
    barIdx = 3'(xPos / BAR_W);

    hsD    = (iEN && hQ < HS_END) ? H_ACTV : ~H_ACTV;
    vsD    = (iEN && vQ < VS_END) ? V_ACTV : ~V_ACTV;
    blankD = act;
    reqD   = iEN && vAct && (hQ >= REQ_START) && (hQ < REQ_END);
    fsD    = iEN && (hQ == '0) && (vQ == '0);
    xD     = act ? xPos : '0;
    yD     = act ? yPos : '0;

    rD = '0;
    gD = '0;
    bD = '0;
    if (act) begin
      case (modeQ)
        2'd0: begin
          rD = inRed;
          gD = inGreen;
          bD = inBlue;
        end
        2'd1: begin
          rD = {COLOR_W{barIdx[2]}};
          gD = {COLOR_W{barIdx[1]}};
          bD = {COLOR_W{barIdx[0]}};
        end
        2'd2: begin
          rD = '1;
          gD = '1;
          bD = '1;
        end
        default: begin
          rD = '0;
          gD = '0;
          bD = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hQ     <= '0;
      vQ     <= '0;
      modeQ  <= '0;
      hsQ    <= ~H_ACTV;
      vsQ    <= ~V_ACTV;
      blankQ <= 1'b0;
      reqQ   <= 1'b0;
      fsQ    <= 1'b0;
      xQ     <= '0;
      yQ     <= '0;
      rQ     <= '0;
      gQ     <= '0;
      bQ     <= '0;
    end else begin
      hQ     <= hD;
      vQ     <= vD;
      modeQ  <= modeD;
      hsQ    <= hsD;
      vsQ    <= vsD;
      blankQ <= blankD;
      reqQ   <= reqD;
      fsQ    <= fsD;
      xQ     <= xD;
      yQ     <= yD;
      rQ     <= rD;
      gQ     <= gD;
      bQ     <= bD;
    end
  end

  assign outRequest    = reqQ;
  assign outX          = xQ;
  assign outY          = yQ;
  assign outFrameStart = fsQ;
  assign outVGA_R      = rQ;
  assign outVGA_G      = gQ;
  assign outVGA_B      = bQ;
  assign outVGA_H_SYNC = hsQ;
  assign outVGA_V_SYNC = vsQ;
  assign outVGA_SYNC   = 1'b0;
  assign outVGA_BLANK  = blankQ;

endmodule
